gat_stream_checker: RTL
=======================

GAT_STREAM_CHECKER -- requirements
Module: gat_stream_checker

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent output streams checked.
REQ-002 SHALL have parameter DATA_W, default 16: sample width per channel.
REQ-003 SHALL have parameter DEPTH, default 2708: expected samples per channel per run.
REQ-004 SHALL have parameter TOL, default 0: maximum accepted absolute difference, in LSBs.
REQ-005 SHALL have parameter SIGNED, default 1: 1 = two's-complement compare, 0 = unsigned.
REQ-006 SHALL have parameter CYC_W, default 32: cycle-counter width.
REQ-007 SHALL derive ADDR_W = $clog2(DEPTH) and CNT_W = $clog2(DEPTH+1).
REQ-008 SHALL have port clk  in  1  system clock; all logic is rising-edge.
REQ-009 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-010 SHALL have port start_i  in  1  one-cycle pulse that starts a run.
REQ-011 SHALL have port dut_vld_i  in  NUM_CH  per-channel sample valid.
REQ-012 SHALL have port dut_data_i  in  NUM_CH*DATA_W  per-channel sample, with channel c at bits [c*DATA_W +: DATA_W].
REQ-013 SHALL have port gold_rd_en_o  out  NUM_CH  golden BRAM read enable.
REQ-014 SHALL have port gold_addr_o  out  NUM_CH*ADDR_W  golden BRAM read address.
REQ-015 SHALL have port gold_data_i  in  NUM_CH*DATA_W  golden data, valid exactly 1 cycle after gold_rd_en_o.
REQ-016 SHALL have ports pass_cnt_o and fail_cnt_o, each  out  NUM_CH*CNT_W  per-channel match and mismatch counts.
REQ-017 SHALL have port first_fail_idx_o  out  NUM_CH*ADDR_W  index of the first mismatch per channel.
REQ-018 SHALL have port first_fail_vld_o  out  NUM_CH  first_fail_idx_o is meaningful.
REQ-019 SHALL have port overflow_o  out  NUM_CH  sticky: channel received more than DEPTH samples.
REQ-020 SHALL have port latency_o  out  CYC_W  cycles from start to the first channel-0 sample.
REQ-021 SHALL have port total_cyc_o  out  CYC_W  cycles from start to done.
REQ-022 SHALL have ports busy_o  out  1 and done_o  out  1  run status.

Function
REQ-023 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
- IDLE->RUN on start_i.
- RUN->DRAIN in the cycle after every channel's sample count reaches DEPTH.
- DRAIN->DONE after 1 cycle.
- DONE->RUN on start_i.
REQ-024 SHALL, on a start_i-driven transition into RUN, clear in that same edge: all counts, first_fail_*, overflow_o, latency_o, total_cyc_o, and latency-captured flag.
REQ-025 SHALL ignore start_i in RUN and DRAIN.
REQ-026 SHALL ignore dut_vld_i outside RUN, except that no samples are accepted in DRAIN.
REQ-027 SHALL, on a channel valid in RUN with count k < DEPTH, assert gold_rd_en_o[c] combinationally and drive gold_addr_o[c] = k, then register the sample and increment k.
REQ-028 SHALL accept back-to-back valids on any channel: one sample per channel per cycle, no backpressure.
REQ-029 SHALL compare the registered sample with gold_data_i one cycle later (stage 2) and update pass_cnt or fail_cnt in that edge; total latency sample->count is 2 cycles.
REQ-030 SHALL compute the difference at DATA_W+1 bits, signed or unsigned per SIGNED; pass iff |diff| <= TOL.
REQ-031 SHALL, on the first fail per run, capture the sample index into first_fail_idx_o and set first_fail_vld_o; later fails do not change it.
REQ-032 SHALL treat a valid with count == DEPTH in RUN as follows: set overflow_o[c], issue no golden read, update no counts.
REQ-033 SHALL increment total_cyc_o every cycle in RUN and DRAIN, saturating at all-ones.
REQ-034 SHALL increment latency_o every cycle in RUN until the first dut_vld_i[0] is seen, then freeze it; saturate at all-ones.
REQ-035 SHALL drive busy_o = 1 in RUN or DRAIN, and done_o = 1 in DONE.
REQ-036 SHALL let the DRAIN state complete the final stage-2 compare, so that at done_o pass_cnt + fail_cnt = DEPTH for every channel without overflow.
REQ-037 SHALL hold all results stable in DONE until the next start_i.
REQ-038 SHALL process channels independently; simultaneous valids on all channels in one cycle are all checked.

Reset
REQ-039 SHALL, on rst_n low, asynchronously force the FSM to IDLE and all outputs and counters to 0, gold_rd_en_o included.
REQ-040 SHALL, on reset asserted mid-RUN, discard in-flight stage-2 compares, and SHALL require a new start_i after release.

Verification
REQ-041 NUM_CH=4, DEPTH=8, TOL=0; start, then 8 matching samples per channel back-to-back -> pass_cnt=8, fail_cnt=0 on all channels, done_o 3 cycles after the last sample edge.
REQ-042 Channel 2 sample index 5 off by +1, TOL=0 -> fail_cnt[2]=1, first_fail_idx[2]=5, pass_cnt[2]=7; with TOL=1 the same stimulus -> fail_cnt[2]=0.
REQ-043 SIGNED=1: dut=16'h8000, gold=16'h7FFF -> fail (diff = -65535 at 17 bits), with no wrap-around false pass.
REQ-044 First channel-0 valid 12 cycles after start -> latency_o=12; with a 9th sample on channel 1 -> overflow_o[1]=1 and counts unchanged.
REQ-045 rst_n low for 1 cycle after 4 samples -> all outputs 0, FSM in IDLE; a fresh start then a full run -> correct counts with no residue.
REQ-046 start_i pulsed during RUN -> no effect; start_i in DONE -> results cleared and a new run begins.

Source files
------------

// File: rtl/gat_stream_checker.sv
// Compares NUM_CH DUT output streams against golden BRAM contents, counting
// matches and mismatches per channel and measuring start latency and run length.
module gat_stream_checker #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2708,
  parameter int TOL    = 0,
  parameter int SIGNED = 1,
  parameter int CYC_W  = 32,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [NUM_CH-1:0]          dut_vld_i,
  input  logic [NUM_CH*DATA_W-1:0]   dut_data_i,
  output logic [NUM_CH-1:0]          gold_rd_en_o,
  output logic [NUM_CH*ADDR_W-1:0]   gold_addr_o,
  input  logic [NUM_CH*DATA_W-1:0]   gold_data_i,
  output logic [NUM_CH*CNT_W-1:0]    pass_cnt_o,
  output logic [NUM_CH*CNT_W-1:0]    fail_cnt_o,
  output logic [NUM_CH*ADDR_W-1:0]   first_fail_idx_o,
  output logic [NUM_CH-1:0]          first_fail_vld_o,
  output logic [NUM_CH-1:0]          overflow_o,
  output logic [CYC_W-1:0]           latency_o,
  output logic [CYC_W-1:0]           total_cyc_o,
  output logic                       busy_o,
  output logic                       done_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [DATA_W:0]  TOL_C   = (DATA_W + 1)'(TOL);

  state_e             state_q, state_d;
  logic [NUM_CH-1:0]  full;
  logic               run, clr;
  logic [CYC_W-1:0]   lat_q, lat_d, tot_q, tot_d;
  logic               lat_cap_q, lat_cap_d;

  assign run = (state_q == ST_RUN);
  // A start pulse is only honoured from IDLE or DONE; it also clears all results.
  assign clr = start_i && (state_q == ST_IDLE || state_q == ST_DONE);

  // NOTE: every always_comb assigns defaults first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_RUN;
      ST_RUN:   if (&full)   state_d = ST_DRAIN;
      ST_DRAIN:              state_d = ST_DONE;
      ST_DONE:  if (start_i) state_d = ST_RUN;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lat_d     = lat_q;
    lat_cap_d = lat_cap_q;
    tot_d     = tot_q;
    if (clr) begin
      lat_d     = '0;
      lat_cap_d = 1'b0;
      tot_d     = '0;
    end else begin
      if (run && !lat_cap_q) begin
        if (!(&lat_q)) lat_d = lat_q + 1'b1;
        lat_cap_d = dut_vld_i[0];
      end
      if ((run || state_q == ST_DRAIN) && !(&tot_q)) tot_d = tot_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lat_q     <= '0;
      lat_cap_q <= 1'b0;
      tot_q     <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      lat_cap_q <= lat_cap_d;
      tot_q     <= tot_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0]  cnt_q, cnt_d, pass_q, pass_d, fail_q, fail_d;
    logic [DATA_W-1:0] smp_q, smp_d;
    logic [ADDR_W-1:0] idx_q, idx_d, ffi_q, ffi_d;
    logic              s2_q, s2_d, ffv_q, ffv_d, ovf_q, ovf_d;
    logic [DATA_W-1:0] dut_smp, gold_smp;
    logic [DATA_W:0]   dut_x, gold_x, diff, mag;
    logic              accept, match;

    assign dut_smp  = dut_data_i[c*DATA_W +: DATA_W];
    assign gold_smp = gold_data_i[c*DATA_W +: DATA_W];
    assign full[c]  = (cnt_q == DEPTH_C);
    assign accept   = run && dut_vld_i[c] && !full[c];

    // One extra bit keeps the difference of two extreme samples from wrapping.
    assign dut_x  = {(SIGNED != 0) && smp_q[DATA_W-1], smp_q};
    assign gold_x = {(SIGNED != 0) && gold_smp[DATA_W-1], gold_smp};
    assign diff   = dut_x - gold_x;
    assign mag    = diff[DATA_W] ? -diff : diff;
    assign match  = (mag <= TOL_C);

    always_comb begin
      cnt_d  = cnt_q;
      pass_d = pass_q;
      fail_d = fail_q;
      smp_d  = smp_q;
      idx_d  = idx_q;
      ffi_d  = ffi_q;
      ffv_d  = ffv_q;
      ovf_d  = ovf_q;
      s2_d   = accept;
      if (accept) begin
        cnt_d = cnt_q + 1'b1;
        smp_d = dut_smp;
        idx_d = cnt_q[ADDR_W-1:0];
      end
      if (run && dut_vld_i[c] && full[c]) ovf_d = 1'b1;
      if (s2_q) begin
        if (match) begin
          pass_d = pass_q + 1'b1;
        end else begin
          fail_d = fail_q + 1'b1;
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = idx_q;
          end
        end
      end
      if (clr) begin
        cnt_d  = '0;
        pass_d = '0;
        fail_d = '0;
        ffi_d  = '0;
        ffv_d  = 1'b0;
        ovf_d  = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        pass_q <= '0;
        fail_q <= '0;
        smp_q  <= '0;
        idx_q  <= '0;
        ffi_q  <= '0;
        s2_q   <= 1'b0;
        ffv_q  <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        pass_q <= pass_d;
        fail_q <= fail_d;
        smp_q  <= smp_d;
        idx_q  <= idx_d;
        ffi_q  <= ffi_d;
        s2_q   <= s2_d;
        ffv_q  <= ffv_d;
        ovf_q  <= ovf_d;
      end
    end

    assign gold_rd_en_o[c]                         = accept;
    assign gold_addr_o[c*ADDR_W +: ADDR_W]         = cnt_q[ADDR_W-1:0];
    assign pass_cnt_o[c*CNT_W +: CNT_W]            = pass_q;
    assign fail_cnt_o[c*CNT_W +: CNT_W]            = fail_q;
    assign first_fail_idx_o[c*ADDR_W +: ADDR_W]    = ffi_q;
    assign first_fail_vld_o[c]                     = ffv_q;
    assign overflow_o[c]                           = ovf_q;
  end

  assign latency_o   = lat_q;
  assign total_cyc_o = tot_q;
  assign busy_o      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done_o      = (state_q == ST_DONE);

endmodule
